clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
- Parametrised, multi-channel successor to the single fixed-divisor clock divider.
- Generates CHANNELS independent divided enable-clocks from the 50 MHz system clock.
- Each channel has a runtime-programmable period and high time, a per-channel enable, and a one-cycle tick strobe.
- New settings are staged through a valid/ready config port and applied glitch-free at the channel's period boundary.
- Feeds LED blinkers, display scan and UART/sample timing logic.

Parameters:
- CHANNELS, 4, number of independent divider channels (1..16).
- CNT_W, 28, width of the period and high-time counters and config fields.
- DEF_DIV, 28'd50000000, period in clk50M cycles loaded at reset; must be >= 2 and < 2^CNT_W.
- DEF_HIGH, 28'd25000000, high time in cycles loaded at reset.
- CH_W, max(1, clog2(CHANNELS)), derived width of the channel select.

Ports:
- clk50M  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  CHANNELS  per-channel run enable.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config port can accept a request (combinational on cfg_ch).
- cfg_ch  in  CH_W  target channel.
- cfg_div  in  CNT_W  new period, in cycles.
- cfg_high  in  CNT_W  new high time, in cycles.
- cfg_err  out  1  one-cycle pulse on a rejected request.
- clk_out  out  CHANNELS  divided clock, registered.
- tick  out  CHANNELS  one-cycle pulse at each period start, registered.

Behaviour:
- Reset (async, while rst_n=0):
  - cnt=0, div=DEF_DIV, high=DEF_HIGH, pending=0 on every channel.
  - clk_out=0, tick=0, cfg_err=0.
  - Reset mid-period takes effect immediately and discards all pending configs.
- Per-channel counting, en[i]=1:
  - cnt <= (cnt >= div-1) ? 0 : cnt+1.
  - clk_out[i] <= (cnt < high).
  - tick[i] <= (cnt == 0).
  - Outputs lag the counter by exactly 1 cycle.
  - Period is div cycles; high time is min(high, div) cycles.
  - high=0 gives constant 0; high >= div gives constant 1. tick still pulses every div cycles in both cases.
- en[i]=0:
  - cnt held at 0; clk_out[i] and tick[i] go to 0 next cycle.
- en[i] rising:
  - First enabled cycle counts from 0, so tick[i]=1 and clk_out[i]=1 (if high>0) on the following cycle.
- Config handshake:
  - A request is accepted when cfg_valid && cfg_ready.
  - cfg_ready = !pending[cfg_ch] (1 for an out-of-range cfg_ch).
  - Accepted values are written to the channel's shadow registers and set pending.
- Apply:
  - Enabled channel: at its wrap cycle (cnt >= div-1), div/high load from shadow, cnt goes to 0, pending clears.
  - Disabled channel: applies on the cycle after acceptance.
  - cfg_ready for that channel returns high the cycle after apply.
  - The period in progress always completes with the old values; no runt pulses.
- Rejection:
  - cfg_div < 2, or cfg_ch >= CHANNELS: request is accepted (ready honoured) but discarded.
  - cfg_err=1 for exactly one cycle; no state change.
- Simultaneous events:
  - An accept on the same cycle as that channel's wrap cannot occur, because pending blocks it.
  - An accept on channel A while channel B wraps is independent.
  - en falling on the same cycle as an apply: the apply still takes effect; the counter goes to 0.
- Arithmetic:
  - All compares are unsigned CNT_W-bit.
  - The counter never exceeds div-1, including after div shrinks at apply.

Optional Feature:
- Macro: CLKDIV_SYNC_EN.
- Defined:
  - Adds input port sync_pulse (1 bit).
  - When sync_pulse=1, every enabled channel forces cnt to 0 and applies any pending config on that cycle.
  - All ticks then pulse together on the next cycle (phase alignment).
  - sync_pulse takes priority over wrap.
- Undefined: port absent; channels free-run independently.

Test Plan:
1. Params CHANNELS=3, CNT_W=8, DEF_DIV=10, DEF_HIGH=5. Release reset, en=3'b001 -> clk_out[0] is 5 high / 5 low, tick[0] every 10 cycles, first tick 1 cycle after en; channels 1 and 2 stay 0.
2. ch0 running; at cnt=3, send cfg ch0 div=4 high=1 -> cfg_ready drops. Old 10-cycle period completes, then period 4 with high 1. cfg_ready rises 1 cycle after apply.
3. cfg ch1 div=6 high=0, then high=6, en[1]=1 -> clk_out[1] constant 0, then constant 1; tick[1] every 6 cycles in both cases.
4. cfg div=1 on ch0, then cfg_ch=3 -> cfg_err pulses 1 cycle each; ch0 period unchanged at 4.
5. Pull rst_n low mid-high phase -> clk_out=0 immediately without a clock edge. After release: period 10, pending cleared, cfg_ready=1.
6. With CLKDIV_SYNC_EN, ch0 div=4 and ch1 div=6 running; pulse sync_pulse -> both ticks assert on the same cycle, one cycle after sync.

Source files
------------

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with staged, boundary-applied config.
// Optional CLKDIV_SYNC_EN adds a sync_pulse input that phase-aligns all enabled channels.
module clk_div_multi #(
  parameter int unsigned      CHANNELS = 4,
  parameter int unsigned      CNT_W    = 28,
  parameter logic [CNT_W-1:0] DEF_DIV  = 28'd50000000,
  parameter logic [CNT_W-1:0] DEF_HIGH = 28'd25000000,
  localparam int unsigned     CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk50M,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] en,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_div,
  input  logic [CNT_W-1:0]    cfg_high,
`ifdef CLKDIV_SYNC_EN
  input  logic                sync_pulse,
`endif
  output logic                cfg_err,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick
);

  logic [CNT_W-1:0] cnt_q   [CHANNELS];
  logic [CNT_W-1:0] cnt_d   [CHANNELS];
  logic [CNT_W-1:0] div_q   [CHANNELS];
  logic [CNT_W-1:0] div_d   [CHANNELS];
  logic [CNT_W-1:0] high_q  [CHANNELS];
  logic [CNT_W-1:0] high_d  [CHANNELS];
  logic [CNT_W-1:0] sdiv_q  [CHANNELS];
  logic [CNT_W-1:0] sdiv_d  [CHANNELS];
  logic [CNT_W-1:0] shigh_q [CHANNELS];
  logic [CNT_W-1:0] shigh_d [CHANNELS];

  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] clk_d, tick_d;
  logic [CHANNELS-1:0] bound_c, apply_c, hit_c;
  logic                sync_c, ch_ok_c, div_ok_c, accept_c, cfg_err_d;

`ifdef CLKDIV_SYNC_EN
  assign sync_c = sync_pulse;
`else
  assign sync_c = 1'b0;
`endif

  // Ready reflects the addressed channel's pending flag; out-of-range channels are always ready.
  always_comb begin : ready_comb
    cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = !pend_q[i];
    end
  end

  assign ch_ok_c   = 32'(cfg_ch) < CHANNELS;
  assign div_ok_c  = cfg_div >= CNT_W'(2);
  assign accept_c  = cfg_valid && cfg_ready;
  assign cfg_err_d = accept_c && !(ch_ok_c && div_ok_c);

  // Per-channel counting, boundary detection and shadow-to-active transfer.
  always_comb begin : chan_comb
    bound_c = '0;
    apply_c = '0;
    hit_c   = '0;
    clk_d   = '0;
    tick_d  = '0;
    pend_d  = pend_q;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i]   = cnt_q[i];
      div_d[i]   = div_q[i];
      high_d[i]  = high_q[i];
      sdiv_d[i]  = sdiv_q[i];
      shigh_d[i] = shigh_q[i];

      if (en[i]) begin
        clk_d[i]   = cnt_q[i] < high_q[i];
        tick_d[i]  = cnt_q[i] == '0;
        bound_c[i] = sync_c || (cnt_q[i] >= div_q[i] - CNT_W'(1));
        cnt_d[i]   = bound_c[i] ? '0 : cnt_q[i] + CNT_W'(1);
      end else begin
        bound_c[i] = 1'b1;
        cnt_d[i]   = '0;
      end

      apply_c[i] = pend_q[i] && bound_c[i];
      if (apply_c[i]) begin
        div_d[i]  = sdiv_q[i];
        high_d[i] = shigh_q[i];
        pend_d[i] = 1'b0;
      end

      // Accept requires !pend_q, so it never collides with an apply on the same channel.
      hit_c[i] = accept_c && ch_ok_c && div_ok_c && (cfg_ch == CH_W'(i));
      if (hit_c[i]) begin
        sdiv_d[i]  = cfg_div;
        shigh_d[i] = cfg_high;
        pend_d[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk50M or negedge rst_n) begin : state_ff
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]   <= '0;
        div_q[i]   <= DEF_DIV;
        high_q[i]  <= DEF_HIGH;
        sdiv_q[i]  <= DEF_DIV;
        shigh_q[i] <= DEF_HIGH;
      end
      pend_q  <= '0;
      clk_out <= '0;
      tick    <= '0;
      cfg_err <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]   <= cnt_d[i];
        div_q[i]   <= div_d[i];
        high_q[i]  <= high_d[i];
        sdiv_q[i]  <= sdiv_d[i];
        shigh_q[i] <= shigh_d[i];
      end
      pend_q  <= pend_d;
      clk_out <= clk_d;
      tick    <= tick_d;
      cfg_err <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: a behavioural model predicts each cycle's outputs into a scoreboard queue.
module tb_clk_div_multi;
  localparam int unsigned NCH = 3;
  localparam int unsigned W   = 8;

  logic           clk50M = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] en;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [1:0]     cfg_ch;
  logic [W-1:0]   cfg_div;
  logic [W-1:0]   cfg_high;
  logic           cfg_err;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
  logic           sync_pulse;

  always #10 clk50M = ~clk50M;

  clk_div_multi #(
    .CHANNELS(NCH), .CNT_W(W), .DEF_DIV(8'd10), .DEF_HIGH(8'd5)
  ) dut (
    .clk50M(clk50M), .rst_n(rst_n), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_high(cfg_high),
`ifdef CLKDIV_SYNC_EN
    .sync_pulse(sync_pulse),
`endif
    .cfg_err(cfg_err), .clk_out(clk_out), .tick(tick)
  );

  typedef struct packed {
    logic [NCH-1:0] clk;
    logic [NCH-1:0] tck;
    logic           err;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  int             m_cnt[NCH], m_div[NCH], m_high[NCH], m_sdiv[NCH], m_shigh[NCH];
  logic [NCH-1:0] m_pend;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = 0; m_div[c] = 10; m_high[c] = 5; m_sdiv[c] = 10; m_shigh[c] = 5;
    end
    m_pend = '0;
  endtask

  // Predicts outputs after the coming edge from the inputs currently driven.
  task automatic model_step(output exp_t e, output logic rdy);
    int   ch;
    logic acc, good, bnd;
    ch  = int'(cfg_ch);
    rdy = 1'b1;
    if (ch < NCH) rdy = !m_pend[ch];
    acc  = cfg_valid && rdy;
    good = acc && (ch < NCH) && (int'(cfg_div) >= 2);
    e     = '0;
    e.err = acc && !good;
    for (int c = 0; c < NCH; c++) begin
      if (en[c]) begin
        e.clk[c] = m_cnt[c] < m_high[c];
        e.tck[c] = m_cnt[c] == 0;
        bnd      = sync_pulse || (m_cnt[c] + 1 >= m_div[c]);
        m_cnt[c] = bnd ? 0 : m_cnt[c] + 1;
      end else begin
        bnd      = 1'b1;
        m_cnt[c] = 0;
      end
      if (bnd && m_pend[c]) begin
        m_div[c]  = m_sdiv[c];
        m_high[c] = m_shigh[c];
        m_pend[c] = 1'b0;
      end
      if (good && ch == c) begin
        m_sdiv[c]  = int'(cfg_div);
        m_shigh[c] = int'(cfg_high);
        m_pend[c]  = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    exp_t e, got;
    logic rdy;
    model_step(e, rdy);
    check("cfg_ready", 32'(cfg_ready), 32'(rdy));
    sb_q.push_back(e);
    @(posedge clk50M);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'(1), 32'(0));
    end else begin
      got = sb_q.pop_front();
      check("clk_out", 32'(clk_out), 32'(got.clk));
      check("tick", 32'(tick), 32'(got.tck));
      check("cfg_err", 32'(cfg_err), 32'(got.err));
    end
  endtask

  task automatic send_cfg(input logic [1:0] ch, input logic [W-1:0] d, input logic [W-1:0] h);
    cfg_ch    = ch;
    cfg_div   = d;
    cfg_high  = h;
    cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
  endtask

  task automatic run_count(input int n, input int ch, output int t, output int h);
    t = 0;
    h = 0;
    for (int k = 0; k < n; k++) begin
      cycle();
      t += int'(tick[ch]);
      h += int'(clk_out[ch]);
    end
  endtask

  initial begin
    int t, h, other;
    rst_n = 1'b0; en = '0; cfg_valid = 1'b0; cfg_ch = '0;
    cfg_div = '0; cfg_high = '0; sync_pulse = 1'b0;
    model_reset();
    repeat (2) @(posedge clk50M);
    #1;
    check("rst_clk_out", 32'(clk_out), 32'(0));
    check("rst_tick", 32'(tick), 32'(0));
    check("rst_cfg_err", 32'(cfg_err), 32'(0));
    check("rst_cfg_ready", 32'(cfg_ready), 32'(1));
    rst_n = 1'b1;

    // Default 10-cycle period, 5 high, on channel 0 only.
    en = 3'b001;
    cycle();
    check("first_tick", 32'(tick), 32'(3'b001));
    t = 1; h = 1; other = 0;
    for (int k = 1; k < 30; k++) begin
      cycle();
      t += int'(tick[0]);
      h += int'(clk_out[0]);
      other += int'(clk_out[2:1] != 2'b00) + int'(tick[2:1] != 2'b00);
    end
    check("t1_ticks", 32'(t), 32'(3));
    check("t1_highs", 32'(h), 32'(15));
    check("t1_idle_ch", 32'(other), 32'(0));

    // Reprogram channel 0 mid-period; old period finishes first.
    repeat (3) cycle();
    send_cfg(2'd0, 8'd4, 8'd1);
    check("t2_ready_low", 32'(cfg_ready), 32'(0));
    repeat (6) cycle();
    check("t2_ready_back", 32'(cfg_ready), 32'(1));
    run_count(16, 0, t, h);
    check("t2_ticks", 32'(t), 32'(4));
    check("t2_highs", 32'(h), 32'(4));

    // Channel 1: high=0 then high=div.
    send_cfg(2'd1, 8'd6, 8'd0);
    cycle();
    en = 3'b011;
    run_count(12, 1, t, h);
    check("t3_zero_ticks", 32'(t), 32'(2));
    check("t3_zero_highs", 32'(h), 32'(0));
    send_cfg(2'd1, 8'd6, 8'd6);
    repeat (12) cycle();
    run_count(12, 1, t, h);
    check("t3_one_ticks", 32'(t), 32'(2));
    check("t3_one_highs", 32'(h), 32'(12));

    // Rejected requests.
    send_cfg(2'd0, 8'd1, 8'd3);
    check("t4_err_div", 32'(cfg_err), 32'(1));
    cycle();
    check("t4_err_clear", 32'(cfg_err), 32'(0));
    send_cfg(2'd3, 8'd5, 8'd2);
    check("t4_err_ch", 32'(cfg_err), 32'(1));
    cfg_ch = 2'd0;
    run_count(8, 0, t, h);
    check("t4_period4", 32'(t), 32'(2));

    // Async reset with a config pending.
    send_cfg(2'd0, 8'd200, 8'd100);
    check("t5_pre_high", 32'(clk_out[1]), 32'(1));
    rst_n = 1'b0;
    #2;
    check("t5_async_clk", 32'(clk_out), 32'(0));
    check("t5_async_tick", 32'(tick), 32'(0));
    model_reset();
    @(posedge clk50M);
    #1;
    en = 3'b001;
    rst_n = 1'b1;
    check("t5_ready", 32'(cfg_ready), 32'(1));
    run_count(20, 0, t, h);
    check("t5_ticks", 32'(t), 32'(2));
    check("t5_highs", 32'(h), 32'(10));

`ifdef CLKDIV_SYNC_EN
    send_cfg(2'd0, 8'd4, 8'd2);
    send_cfg(2'd1, 8'd6, 8'd3);
    en = 3'b011;
    repeat (20) cycle();
    sync_pulse = 1'b1;
    cycle();
    sync_pulse = 1'b0;
    cycle();
    check("t6_sync_ticks", 32'(tick[1:0]), 32'(2'b11));
    repeat (12) cycle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
